// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl
// Execute-stage sequencer for ARM data-processing instructions. Accepts one
// decoded instruction per handshake, tests its condition field against the
// NZCV register held here, drives the external ALU for one cycle, then issues
// a single-cycle register writeback and the flag update.
//
// Build option: ALU_EXEC_COND_EN
//   defined   - cond is evaluated; failing instructions retire as skipped.
//   undefined - cond is ignored and every instruction executes (as AL).
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   in_valid / in_ready    instruction handshake from decode
//   cond, opcode, s_bit    condition, ALU opcode, set-flags request
//   rd                     destination register
//   op_a, op_b             Rn value and barrel-shifter output
//   shifter_carry          barrel-shifter carry-out (C for logical ops)
//   alu_opcode/a/b/carry_in  drive to the combinational ALU (EXEC only)
//   alu_result, alu_nzvc   ALU response, nzvc = {N,Z,V,C}
//   wb_en/addr/data        one-cycle register-file write
//   flush                  asserted with wb_en when writing R15
//   done                   one-cycle pulse per retired instruction
//   flags                  current {N,Z,V,C}
module alu_exec_ctrl #(
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        cond,
    input  logic [3:0]        opcode,
    input  logic              s_bit,
    input  logic [REG_AW-1:0] rd,
    input  logic [31:0]       op_a,
    input  logic [31:0]       op_b,
    input  logic              shifter_carry,
    output logic [3:0]        alu_opcode,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic              alu_carry_in,
    input  logic [31:0]       alu_result,
    input  logic [3:0]        alu_nzvc,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr,
    output logic [31:0]       wb_data,
    output logic              flush,
    output logic              done,
    output logic [3:0]        flags
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t            state;
    logic [3:0]        op_q;
    logic              s_q;
    logic [REG_AW-1:0] rd_q;
    logic              sc_q;
    logic [3:0]        nzvc_q;
    logic              take;
    logic              skipped;

    // TST/TEQ/CMP/CMN: flags always update, never write a register
    function automatic logic is_compare(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

    function automatic logic is_arith(input logic [3:0] op);
        return (op >= 4'h2 && op <= 4'h7) || op == 4'hA || op == 4'hB;
    endfunction

`ifdef ALU_EXEC_COND_EN
    logic skip_q;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy;
        {n, z, v, cy} = f;
        case (c)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return cy;
            4'h3:    return !cy;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return cy && !z;
            4'h9:    return !cy || z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return z || (n != v);
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign take    = cond_pass(cond, flags);
    assign skipped = skip_q;
`else
    logic cond_unused;
    assign cond_unused = ^cond;
    assign take        = 1'b1;
    assign skipped     = 1'b0;
`endif

    // All outputs are registered; the ALU drive is loaded on acceptance so it
    // is present for exactly the EXEC cycle, and writeback is loaded on
    // leaving EXEC so it is present for exactly the WB cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            flags        <= 4'h0;
            alu_opcode   <= 4'h0;
            alu_a        <= 32'h0;
            alu_b        <= 32'h0;
            alu_carry_in <= 1'b0;
            wb_en        <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= 32'h0;
            flush        <= 1'b0;
            done         <= 1'b0;
            op_q         <= 4'h0;
            s_q          <= 1'b0;
            rd_q         <= '0;
            sc_q         <= 1'b0;
            nzvc_q       <= 4'h0;
`ifdef ALU_EXEC_COND_EN
            skip_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        op_q     <= opcode;
                        s_q      <= s_bit;
                        rd_q     <= rd;
                        sc_q     <= shifter_carry;
                        if (take) begin
                            state        <= EXEC;
                            alu_opcode   <= opcode;
                            alu_a        <= op_a;
                            alu_b        <= op_b;
                            alu_carry_in <= flags[0];
                        end
`ifdef ALU_EXEC_COND_EN
                        else begin
                            state  <= WB;
                            done   <= 1'b1;
                            skip_q <= 1'b1;
                        end
`endif
                    end
                end
                EXEC: begin
                    state        <= WB;
                    nzvc_q       <= alu_nzvc;
                    alu_opcode   <= 4'h0;
                    alu_a        <= 32'h0;
                    alu_b        <= 32'h0;
                    alu_carry_in <= 1'b0;
                    done         <= 1'b1;
                    if (!is_compare(op_q)) begin
                        wb_en   <= 1'b1;
                        wb_addr <= rd_q;
                        wb_data <= alu_result;
                        flush   <= (rd_q == REG_AW'(15));
                    end
                end
                WB: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    done     <= 1'b0;
                    wb_en    <= 1'b0;
                    wb_addr  <= '0;
                    wb_data  <= 32'h0;
                    flush    <= 1'b0;
`ifdef ALU_EXEC_COND_EN
                    skip_q   <= 1'b0;
`endif
                    // Logical ops take C from the shifter and keep V
                    if (!skipped && (s_q || is_compare(op_q))) begin
                        if (is_arith(op_q))
                            flags <= nzvc_q;
                        else
                            flags <= {nzvc_q[3], nzvc_q[2], flags[1], sc_q};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Testbench for alu_exec_ctrl: directed cases plus randomized instructions,
// with a stub ALU and a scoreboard drained by an independent monitor.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  cond = 4'h0;
    logic [3:0]  opcode = 4'h0;
    logic        s_bit = 1'b0;
    logic [3:0]  rd = 4'h0;
    logic [31:0] op_a = 32'h0;
    logic [31:0] op_b = 32'h0;
    logic        shifter_carry = 1'b0;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_carry_in;
    logic [31:0] alu_result;
    logic [3:0]  alu_nzvc;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        done;
    logic [3:0]  flags;

    alu_exec_ctrl #(.REG_AW(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .cond(cond), .opcode(opcode), .s_bit(s_bit), .rd(rd),
        .op_a(op_a), .op_b(op_b), .shifter_carry(shifter_carry),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_carry_in(alu_carry_in), .alu_result(alu_result),
        .alu_nzvc(alu_nzvc), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .flush(flush), .done(done), .flags(flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        int          cyc;
        logic        wb;
        logic [3:0]  addr;
        logic [31:0] data;
        logic        flush;
        logic [3:0]  flags;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] mflags = 4'h0;

    // ARM data-processing arithmetic: returns {N,Z,V,C, result}
    function automatic logic [35:0] arm_op(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin);
        logic [31:0] x, y, res;
        logic        ci, c, v, arith;
        logic [32:0] sum;
        x = 32'h0; y = 32'h0; ci = 1'b0; res = 32'h0; c = 1'b0; v = 1'b0;
        arith = 1'b1;
        case (op)
            4'h0, 4'h8: begin res = a & b;  arith = 1'b0; end
            4'h1, 4'h9: begin res = a ^ b;  arith = 1'b0; end
            4'h2, 4'hA: begin x = a; y = ~b; ci = 1'b1; end
            4'h3:       begin x = b; y = ~a; ci = 1'b1; end
            4'h4, 4'hB: begin x = a; y = b;  ci = 1'b0; end
            4'h5:       begin x = a; y = b;  ci = cin;  end
            4'h6:       begin x = a; y = ~b; ci = cin;  end
            4'h7:       begin x = b; y = ~a; ci = cin;  end
            4'hC:       begin res = a | b;  arith = 1'b0; end
            4'hD:       begin res = b;      arith = 1'b0; end
            4'hE:       begin res = a & ~b; arith = 1'b0; end
            default:    begin res = ~b;     arith = 1'b0; end
        endcase
        if (arith) begin
            sum = {1'b0, x} + {1'b0, y} + {32'h0, ci};
            res = sum[31:0];
            c   = sum[32];
            v   = (x[31] == y[31]) && (res[31] != x[31]);
        end
        return {res[31], res == 32'h0, v, c, res};
    endfunction

    function automatic logic op_is_arith(input logic [3:0] op);
        return op inside {[4'h2:4'h7], 4'hA, 4'hB};
    endfunction

`ifdef ALU_EXEC_COND_EN
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy;
        {n, z, v, cy} = f;
        case (c)
            4'h0: return z;           4'h1: return !z;
            4'h2: return cy;          4'h3: return !cy;
            4'h4: return n;           4'h5: return !n;
            4'h6: return v;           4'h7: return !v;
            4'h8: return cy & !z;     4'h9: return !cy | z;
            4'hA: return n == v;      4'hB: return n != v;
            4'hC: return !z & (n == v);
            4'hD: return z | (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
`endif

    // Stub ALU; for logical ops it reports junk V/C so the controller must
    // take C from the shifter and preserve V itself.
    logic [35:0] stub_r;
    always_comb begin
        stub_r     = arm_op(alu_opcode, alu_a, alu_b, alu_carry_in);
        alu_result = stub_r[31:0];
        alu_nzvc   = stub_r[35:32];
        if (!op_is_arith(alu_opcode))
            alu_nzvc[1:0] = {1'b1, ~alu_carry_in};
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one instruction and, when push_exp is set, advance the model and
    // queue the expected retirement. Returns at the falling edge of T+1.
    task automatic applyStimulus(input logic [3:0] c, input logic [3:0] op, input logic s,
                                 input logic [3:0] d, input logic [31:0] a, input logic [31:0] b,
                                 input logic sc, input bit push_exp);
        bit          got_ready;
        logic        pass, cmp_cls;
        logic [35:0] r;
        logic [3:0]  newf, oldf;
        exp_t        e;
        int          t;
        got_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (in_ready) begin got_ready = 1'b1; break; end
        end
        if (!got_ready) begin
            n_cmp++; n_fail++;
            $display("[TB] FAIL ready_timeout: in_ready stayed 0, expected 1 within 20 cycles");
            return;
        end
        cond = c; opcode = op; s_bit = s; rd = d; op_a = a; op_b = b;
        shifter_carry = sc; in_valid = 1'b1;
        t    = cyc;
        oldf = mflags;
`ifdef ALU_EXEC_COND_EN
        pass = cond_ok(c, mflags);
`else
        pass = 1'b1;
`endif
        cmp_cls = (op >= 4'h8 && op <= 4'hB);
        r       = arm_op(op, a, b, mflags[0]);
        newf    = mflags;
        if (pass && (s || cmp_cls))
            newf = op_is_arith(op) ? r[35:32] : {r[35], r[34], mflags[1], sc};
        if (push_exp) begin
            e.cyc   = t + (pass ? 2 : 1);
            e.wb    = pass && !cmp_cls;
            e.addr  = d;
            e.data  = r[31:0];
            e.flush = pass && !cmp_cls && (d == 4'hF);
            e.flags = newf;
            sb.push_back(e);
            mflags = newf;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("busy_ready", {31'h0, in_ready}, 32'h0);
        checkOutput("alu_opcode", {28'h0, alu_opcode}, pass ? {28'h0, op} : 32'h0);
        checkOutput("alu_a", alu_a, pass ? a : 32'h0);
        checkOutput("alu_b", alu_b, pass ? b : 32'h0);
        checkOutput("alu_cin", {31'h0, alu_carry_in}, pass ? {31'h0, oldf[0]} : 32'h0);
    endtask

    // Monitor: retires scoreboard entries on done and checks flags next cycle
    bit         pend = 1'b0;
    logic [3:0] pend_flags = 4'h0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    checkOutput("flags_after", {28'h0, flags}, {28'h0, pend_flags});
                    pend = 1'b0;
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("[TB] FAIL unexpected_done: done=1 with no instruction pending, expected done=0 (cycle %0d)", cyc);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("done_cycle", 32'(cyc), 32'(e.cyc));
                        checkOutput("wb_en", {31'h0, wb_en}, {31'h0, e.wb});
                        checkOutput("flush", {31'h0, flush}, {31'h0, e.flush});
                        if (e.wb) begin
                            checkOutput("wb_addr", {28'h0, wb_addr}, {28'h0, e.addr});
                            checkOutput("wb_data", wb_data, e.data);
                        end
                        pend       = 1'b1;
                        pend_flags = e.flags;
                    end
                end else if (wb_en || flush) begin
                    checkOutput("stray_wb", {30'h0, wb_en, flush}, 32'h0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] edge_vals [4];
        logic [31:0] a, b;
        edge_vals[0] = 32'h0; edge_vals[1] = 32'h7FFFFFFF;
        edge_vals[2] = 32'h80000000; edge_vals[3] = 32'hFFFFFFFF;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", {31'h0, in_ready}, 32'h1);
        checkOutput("rst_flags", {28'h0, flags}, 32'h0);
        checkOutput("rst_done", {31'h0, done}, 32'h0);
        checkOutput("rst_wb_en", {31'h0, wb_en}, 32'h0);
        checkOutput("rst_flush", {31'h0, flush}, 32'h0);
        checkOutput("rst_alu_a", alu_a, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // ADDS overflow, CMP equal, conditional MOVs
        applyStimulus(4'hE, 4'h4, 1'b1, 4'd3, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1);
        applyStimulus(4'hE, 4'hA, 1'b0, 4'd0, 32'h5, 32'h5, 1'b0, 1'b1);
        applyStimulus(4'h1, 4'hD, 1'b0, 4'd2, 32'h0, 32'hAA, 1'b0, 1'b1);
        applyStimulus(4'h0, 4'hD, 1'b0, 4'd2, 32'h0, 32'hAA, 1'b0, 1'b1);
        // Clear flags, then MOVS with shifter carry and MVN without S
        applyStimulus(4'hE, 4'h4, 1'b1, 4'd1, 32'h1, 32'h1, 1'b0, 1'b1);
        applyStimulus(4'hE, 4'hD, 1'b1, 4'd4, 32'h0, 32'h0, 1'b1, 1'b1);
        applyStimulus(4'hE, 4'hF, 1'b0, 4'd5, 32'h0, 32'h12345678, 1'b0, 1'b1);
        // V set, then logical S op must keep it
        applyStimulus(4'hE, 4'h4, 1'b1, 4'd6, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1);
        applyStimulus(4'hE, 4'h0, 1'b1, 4'd7, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b1);
        // R15 writeback
        applyStimulus(4'hE, 4'hC, 1'b0, 4'd15, 32'h100, 32'h4, 1'b0, 1'b1);

        // Reset while the ADD is in EXEC
        applyStimulus(4'hE, 4'h4, 1'b1, 4'd8, 32'h1, 32'h2, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset  = 1'b0;
        mflags = 4'h0;
        @(negedge clk);
        checkOutput("rexec_in_ready", {31'h0, in_ready}, 32'h1);
        checkOutput("rexec_flags", {28'h0, flags}, 32'h0);
        checkOutput("rexec_wb_en", {31'h0, wb_en}, 32'h0);
        checkOutput("rexec_done", {31'h0, done}, 32'h0);

        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          a, b, 1'($urandom_range(0, 1)), 1'b1);
        end

        repeat (6) @(posedge clk);
        @(negedge clk);
        checkOutput("sb_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
